bk_slot_ctrl: RTL and testbench
===============================

BK_SLOT_CTRL -- requirements
Module: bk_slot_ctrl

Interface
- REQ-001 SHALL have parameter SECT_W, default 6, giving log2 of the sectors per save slot (64).
- REQ-002 SHALL have parameter TMO_W, default 24, giving the width of the watchdog counter.
- REQ-003 SHALL have port clk_sys, input, 1, the single system clock; all logic is clocked on its rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port downloading, input, 1, high while a ROM download is in progress.
- REQ-006 SHALL have ports img_mounted, input, 1, a pulse; img_readonly, input, 1; and img_size_nz, input, 1, meaning the image size is nonzero.
- REQ-007 SHALL have ports load_req and save_req, each input, 1, level-type menu status bits.
- REQ-008 SHALL have port slot, input, 2, the save slot index.
- REQ-009 SHALL have port sd_lba, output, 32, the sector address.
- REQ-010 SHALL have ports sd_rd and sd_wr, each output, 1, sector read and write requests.
- REQ-011 SHALL have port sd_ack, input, 1, high while the host services a sector.
- REQ-012 SHALL have port bk_ena, output, 1, meaning a writable save file is available.
- REQ-013 SHALL have ports bk_loading, output, 1, which holds the core in reset during a load; bk_busy, output, 1; and bk_error, output, 1, a sticky timeout flag.

Function
- REQ-014 bk_ena SHALL clear on the rising edge of downloading.
- REQ-015 bk_ena SHALL set in any cycle where downloading & img_mounted & img_size_nz & ~img_readonly holds; set SHALL win over a simultaneous clear.
- REQ-016 Start events SHALL be rising edges of (load_req & bk_ena) and (save_req & bk_ena), detected against registered previous values.
- REQ-017 The FSM states SHALL be IDLE, REQ, XFER and NEXT.
- REQ-018 IDLE -> REQ on a start event.
  - On entry: slot is latched, the sector counter is set to 0, and bk_loading is set to 1 for a load or 0 for a save.
  - sd_rd or sd_wr is asserted in the following cycle, one cycle of latency.
- REQ-019 If load and save start in the same cycle, load SHALL win.
- REQ-020 Start edges arriving while not in IDLE SHALL be ignored and not queued.
- REQ-021 sd_lba SHALL equal {zero pad, slot_latched, sector}, i.e. {slot,6'd0} + sector at default widths.
- REQ-022 REQ -> XFER on the rising edge of sd_ack; sd_rd and sd_wr SHALL be 0 from the next cycle.
- REQ-023 XFER -> NEXT on the falling edge of sd_ack.
- REQ-024 In NEXT:
  - if the sector counter is all ones, go to IDLE and clear bk_loading and bk_busy;
  - otherwise increment the counter and go to REQ, reasserting the same request type.
- REQ-025 The counter SHALL never wrap into the next slot; the slot bits are not incremented.
- REQ-026 bk_busy SHALL be 1 in every state other than IDLE.
- REQ-027 bk_error SHALL clear on each start event.
- REQ-028 Deassertion of bk_ena or a change of slot during a transfer SHALL NOT abort or alter the transfer.

Reset
- REQ-029 Asynchronous reset SHALL force all of the following, including mid-transfer: state to IDLE, sd_rd, sd_wr, bk_loading, bk_busy, bk_error and bk_ena to 0, sd_lba to 0, and edge registers to 0.
- REQ-030 After reset release, a level already high on load_req or save_req SHALL NOT start a transfer until it falls and rises again.

Configuration
- REQ-031 Macro BK_WATCHDOG_EN defined: a TMO_W-bit counter runs in REQ and XFER and reloads on every sd_ack edge.
  - On overflow: go to IDLE, drop sd_rd, sd_wr and bk_loading, and set bk_error to 1.
- REQ-032 Macro BK_WATCHDOG_EN undefined: no counter is built, bk_error is tied to 0, and the FSM waits on sd_ack indefinitely.

Verification
- REQ-033 Load: bk_ena=1, slot=2, pulse load_req, ack each sector for 3 cycles.
  - Expect 64 sd_rd requests with sd_lba 128..191.
  - Expect bk_loading=1 throughout and 0 after the last ack falls.
- REQ-034 Save: slot=3, save_req rise.
  - Expect sd_wr with lba 192..255, bk_loading=0, and bk_busy to fall after sector 63.
- REQ-035 Simultaneous load_req and save_req rise: expect sd_rd only and bk_loading=1.
- REQ-036 bk_ena path: rise downloading, pulse img_mounted with img_readonly=1, expect bk_ena=0; repeat with img_readonly=0, expect bk_ena=1.
- REQ-037 Reset asserted after sector 10 ack: expect all outputs 0 immediately; with load_req held high, expect no restart after reset release.
- REQ-038 With BK_WATCHDOG_EN and TMO_W=8: never return sd_ack, expect bk_error=1 and sd_rd=0 after 256 cycles; a new start edge clears bk_error.

Source files
------------

// File: rtl/bk_slot_ctrl.sv
// Save-slot backup controller: streams one 64-sector slot between core RAM and the SD host.
// Optional `BK_WATCHDOG_EN` adds a TMO_W-bit sd_ack timeout that aborts a transfer and raises bk_error.
module bk_slot_ctrl #(
    parameter int SECT_W = 6,
    parameter int TMO_W  = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        downloading,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_nz,
    input  logic        load_req,
    input  logic        save_req,
    input  logic [1:0]  slot,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        bk_busy,
    output logic        bk_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    state_t            state;
    logic              dl_q;
    logic              load_q;
    logic              save_q;
    logic              ack_q;
    logic [1:0]        slot_l;
    logic [SECT_W-1:0] sector;
    logic              is_load;

    logic load_lvl;
    logic save_lvl;
    logic load_start;
    logic save_start;
    logic ack_rise;
    logic ack_fall;

    // Handshake: sd_rd/sd_wr is a level request held until the host raises sd_ack;
    // the sector is done when sd_ack falls again, and only then is the next one requested.
    assign load_lvl   = load_req & bk_ena;
    assign save_lvl   = save_req & bk_ena;
    assign load_start = load_lvl & ~load_q;
    assign save_start = save_lvl & ~save_q;
    assign ack_rise   = sd_ack & ~ack_q;
    assign ack_fall   = ~sd_ack & ack_q;

    assign sd_lba    = {{(32 - 2 - SECT_W){1'b0}}, slot_l, sector};
    assign dbg_state = state;

    // A new writable image wins over the clear caused by the download starting.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q   <= 1'b0;
            bk_ena <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (downloading & img_mounted & img_size_nz & ~img_readonly)
                bk_ena <= 1'b1;
            else if (downloading & ~dl_q)
                bk_ena <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            load_q <= 1'b0;
            save_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            load_q <= load_lvl;
            save_q <= save_lvl;
            ack_q  <= sd_ack;
        end
    end

`ifdef BK_WATCHDOG_EN
    logic [TMO_W-1:0] tmo_cnt;
`else
    // Without the watchdog there is nothing to time out; TMO_W is inert here.
    assign bk_error = (TMO_W < 0);
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            slot_l     <= 2'd0;
            sector     <= '0;
            is_load    <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            bk_busy    <= 1'b0;
`ifdef BK_WATCHDOG_EN
            tmo_cnt    <= '0;
            bk_error   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start | save_start) begin
                        state      <= S_REQ;
                        slot_l     <= slot;
                        sector     <= '0;
                        is_load    <= load_start;
                        bk_loading <= load_start;
                        sd_rd      <= load_start;
                        sd_wr      <= ~load_start;
                        bk_busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ack_rise) begin
                        state <= S_XFER;
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (ack_fall)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    // The slot bits never take a carry: the last sector ends the transfer.
                    if (&sector) begin
                        state      <= S_IDLE;
                        bk_loading <= 1'b0;
                        bk_busy    <= 1'b0;
                    end else begin
                        state  <= S_REQ;
                        sector <= sector + 1'b1;
                        sd_rd  <= is_load;
                        sd_wr  <= ~is_load;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef BK_WATCHDOG_EN
            if (state == S_IDLE) begin
                tmo_cnt <= '0;
                if (load_start | save_start)
                    bk_error <= 1'b0;
            end else if (state == S_REQ || state == S_XFER) begin
                if (ack_rise | ack_fall) begin
                    tmo_cnt <= '0;
                end else if (&tmo_cnt) begin
                    state      <= S_IDLE;
                    sd_rd      <= 1'b0;
                    sd_wr      <= 1'b0;
                    bk_loading <= 1'b0;
                    bk_busy    <= 1'b0;
                    bk_error   <= 1'b1;
                    tmo_cnt    <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_bk_slot_ctrl.sv
// Bench for bk_slot_ctrl: transaction-level model with an expected-LBA queue, per-cycle compare.
`timescale 1ns/1ps
module tb_bk_slot_ctrl;
`ifdef BK_WATCHDOG_EN
    localparam int TMO_W = 8;
`else
    localparam int TMO_W = 24;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        downloading = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic        img_size_nz = 1'b0;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic [1:0]  slot = 2'd0;
    logic        sd_ack = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        bk_ena;
    logic        bk_loading;
    logic        bk_busy;
    logic        bk_error;
    logic [1:0]  dbg_state;

    bk_slot_ctrl #(.SECT_W(6), .TMO_W(TMO_W)) dut (
        .clk_sys(clk_sys), .reset(reset), .downloading(downloading),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size_nz(img_size_nz),
        .load_req(load_req), .save_req(save_req), .slot(slot),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .bk_ena(bk_ena), .bk_loading(bk_loading), .bk_busy(bk_busy),
        .bk_error(bk_error), .dbg_state(dbg_state)
    );

    // clock/reset
    always #5 clk_sys = ~clk_sys;

    // model: what the outputs must show right now
    int          checks = 0;
    int          errors = 0;
    bit          m_on = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_loading = 1'b0;
    bit          m_load = 1'b0;
    bit          m_req = 1'b0;
    bit          m_ena = 1'b0;
    bit          m_err = 1'b0;
    bit          dl_pulse = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle
    always @(negedge clk_sys) begin
        if (m_on) begin
            check("bk_busy", {31'd0, bk_busy}, {31'd0, m_busy});
            check("bk_loading", {31'd0, bk_loading}, {31'd0, m_loading});
            check("sd_rd", {31'd0, sd_rd}, {31'd0, m_req && m_load});
            check("sd_wr", {31'd0, sd_wr}, {31'd0, m_req && !m_load});
            check("bk_ena", {31'd0, bk_ena}, {31'd0, m_ena});
            check("bk_error", {31'd0, bk_error}, {31'd0, m_err});
            if (m_req) begin
                if (exp_q.size() == 0)
                    check("exp_q_empty", 32'd1, 32'd0);
                else
                    check("sd_lba", sd_lba, exp_q[0]);
            end
        end
    end

    // driver tasks
    task automatic tick(input bit noise);
        @(posedge clk_sys);
        #1;
        if (dl_pulse) begin
            m_ena = 1'b0;
            downloading = 1'b0;
            dl_pulse = 1'b0;
        end
        if (noise) begin
            if (exp_q.size() > 1) begin
                load_req = 1'($urandom_range(0, 1));
                save_req = 1'($urandom_range(0, 1));
                slot = 2'($urandom_range(0, 3));
                if (m_ena && $urandom_range(0, 99) == 0) begin
                    downloading = 1'b1;
                    dl_pulse = 1'b1;
                end
            end else begin
                load_req = 1'b0;
                save_req = 1'b0;
            end
        end
    endtask

    task automatic mount(input bit ro, input bit nz);
        downloading = 1'b1;
        tick(1'b0);
        m_ena = 1'b0;
        img_mounted = 1'b1;
        img_readonly = ro;
        img_size_nz = nz;
        tick(1'b0);
        m_ena = !ro && nz;
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        downloading = 1'b0;
        tick(1'b0);
    endtask

    task automatic start_xfer(input bit ld, input bit sv, input logic [1:0] sl);
        slot = sl;
        load_req = ld;
        save_req = sv;
        tick(1'b0);
        m_busy = 1'b1;
        m_load = ld;
        m_loading = ld;
        m_req = 1'b1;
        m_err = 1'b0;
        for (int i = 0; i < 64; i++)
            exp_q.push_back(32'(int'(sl) * 64 + i));
        load_req = 1'b0;
        save_req = 1'b0;
    endtask

    // host side: hold 0 means a random ack length of 1..4 cycles
    task automatic serve(input int n, input int hold, input bit noise);
        for (int s = 0; s < n; s++) begin
            int gap;
            int hl;
            gap = $urandom_range(0, 2);
            hl = (hold > 0) ? hold : $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) tick(noise);
            sd_ack = 1'b1;
            tick(noise);
            m_req = 1'b0;
            void'(exp_q.pop_front());
            for (int h = 1; h < hl; h++) tick(noise);
            sd_ack = 1'b0;
            tick(noise);
            tick(noise);
            if (exp_q.size() == 0) begin
                m_busy = 1'b0;
                m_loading = 1'b0;
            end else begin
                m_req = 1'b1;
            end
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_busy", {31'd0, bk_busy}, 32'd0);
        check("rst_lba", sd_lba, 32'd0);
        check("rst_ena", {31'd0, bk_ena}, 32'd0);
        m_on = 1'b1;
        #2 reset = 1'b0;
        tick(1'b0);

        // bk_ena path
        mount(1'b1, 1'b1);
        check("ena_readonly", {31'd0, bk_ena}, 32'd0);
        mount(1'b0, 1'b0);
        check("ena_size_zero", {31'd0, bk_ena}, 32'd0);
        mount(1'b0, 1'b1);
        check("ena_writable", {31'd0, bk_ena}, 32'd1);

        // load slot 2, 3-cycle acks
        start_xfer(1'b1, 1'b0, 2'd2);
        check("load_first_lba", sd_lba, 32'd128);
        check("load_first_rd", {31'd0, sd_rd}, 32'd1);
        serve(63, 3, 1'b0);
        check("load_last_lba", sd_lba, 32'd191);
        check("load_mid_loading", {31'd0, bk_loading}, 32'd1);
        serve(1, 3, 1'b0);
        check("load_done_loading", {31'd0, bk_loading}, 32'd0);
        check("load_done_busy", {31'd0, bk_busy}, 32'd0);

        // save slot 3, with input noise during the transfer
        if (!m_ena) mount(1'b0, 1'b1);
        start_xfer(1'b0, 1'b1, 2'd3);
        check("save_first_lba", sd_lba, 32'd192);
        check("save_first_wr", {31'd0, sd_wr}, 32'd1);
        serve(63, 0, 1'b1);
        check("save_last_lba", sd_lba, 32'd255);
        serve(1, 0, 1'b1);
        check("save_done_busy", {31'd0, bk_busy}, 32'd0);

        // simultaneous load and save: load wins
        if (!m_ena) mount(1'b0, 1'b1);
        start_xfer(1'b1, 1'b1, 2'd1);
        check("both_rd", {31'd0, sd_rd}, 32'd1);
        check("both_wr", {31'd0, sd_wr}, 32'd0);
        check("both_loading", {31'd0, bk_loading}, 32'd1);
        serve(64, 0, 1'b1);

        // random transfers
        for (int t = 0; t < 3; t++) begin
            bit ld;
            bit sv;
            ld = 1'($urandom_range(0, 1));
            sv = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!m_ena) mount(1'b0, 1'b1);
            start_xfer(ld, sv, 2'($urandom_range(0, 3)));
            serve(64, 0, 1'b1);
        end

`ifdef BK_WATCHDOG_EN
        // no ack ever: timeout after 256 cycles in REQ
        if (!m_ena) mount(1'b0, 1'b1);
        start_xfer(1'b1, 1'b0, 2'd1);
        repeat (255) tick(1'b0);
        tick(1'b0);
        m_busy = 1'b0;
        m_req = 1'b0;
        m_loading = 1'b0;
        m_err = 1'b1;
        exp_q.delete();
        check("wdg_error", {31'd0, bk_error}, 32'd1);
        check("wdg_rd", {31'd0, sd_rd}, 32'd0);
        start_xfer(1'b0, 1'b1, 2'd0);
        check("wdg_error_cleared", {31'd0, bk_error}, 32'd0);
        serve(64, 0, 1'b0);
`endif

        // reset in the middle of a load, load_req held high across it
        if (!m_ena) mount(1'b0, 1'b1);
        start_xfer(1'b1, 1'b0, 2'($urandom_range(0, 3)));
        serve(11, 3, 1'b0);
        load_req = 1'b1;
        #2 reset = 1'b1;
        m_busy = 1'b0;
        m_loading = 1'b0;
        m_req = 1'b0;
        m_ena = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_rd", {31'd0, sd_rd}, 32'd0);
        check("mid_rst_busy", {31'd0, bk_busy}, 32'd0);
        check("mid_rst_loading", {31'd0, bk_loading}, 32'd0);
        check("mid_rst_lba", sd_lba, 32'd0);
        check("mid_rst_ena", {31'd0, bk_ena}, 32'd0);
        repeat (2) @(posedge clk_sys);
        #3 reset = 1'b0;
        repeat (10) tick(1'b0);
        check("no_restart_busy", {31'd0, bk_busy}, 32'd0);
        load_req = 1'b0;
        tick(1'b0);

        m_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
